// File: rtl/cpu_defs.sv
// Shared CPU definitions: ALU function codes, operand source
// encodings and the hardwired-zero register index.
package cpu_defs;

  typedef enum logic [5:0] {
    ALU_ADD = 6'b000000,
    ALU_SUB = 6'b000001,
    ALU_AND = 6'b011000,
    ALU_OR  = 6'b011110,
    ALU_XOR = 6'b010110,
    ALU_NOR = 6'b010001,
    ALU_SLL = 6'b100000,
    ALU_SRL = 6'b100001,
    ALU_SRA = 6'b100011,
    ALU_EQ  = 6'b110011,
    ALU_NEQ = 6'b110001,
    ALU_LT  = 6'b110101,
    ALU_LEZ = 6'b111101,
    ALU_LTZ = 6'b111011,
    ALU_GTZ = 6'b111111
  } alu_fun_e;

  localparam logic SRC1_RS    = 1'b0;
  localparam logic SRC1_SHAMT = 1'b1;
  localparam logic SRC2_RT    = 1'b0;
  localparam logic SRC2_IMM   = 1'b1;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID-to-EX bundle: decoded operands and control leaving ID.
// master = decode side, slave = operand stage.
interface ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_shamt;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [REG_AW-1:0] id_rd_addr;
  logic [5:0]        id_ALUFun;
  logic              id_Sign;
  logic              id_ALUSrc1;
  logic              id_ALUSrc2;
  logic              id_RegWrite;
  logic              id_MemRead;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm,
    output id_shamt, id_rs_addr, id_rt_addr, id_rd_addr,
    output id_ALUFun, id_Sign, id_ALUSrc1, id_ALUSrc2,
    output id_RegWrite, id_MemRead
  );

  modport slave (
    input id_valid, id_rs_data, id_rt_data, id_imm,
    input id_shamt, id_rs_addr, id_rt_addr, id_rd_addr,
    input id_ALUFun, id_Sign, id_ALUSrc1, id_ALUSrc2,
    input id_RegWrite, id_MemRead
  );
endinterface

// File: rtl/operand_fwd.sv
// One operand's bypass: MEM result beats WB data beats the
// registered value; register 0 never matches.
module operand_fwd
  import cpu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data
);

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  logic mem_hit;
  logic wb_hit;
  logic wb_sel;
  logic reg_sel;

  assign mem_hit = mem_we & (mem_rd != ZERO) & (mem_rd == src_addr);
  assign wb_hit  = wb_we & (wb_rd != ZERO) & (wb_rd == src_addr);
  // one-hot selects so the decoder is genuinely unique
  assign wb_sel  = wb_hit & ~mem_hit;
  assign reg_sel = ~mem_hit & ~wb_hit;

  always_comb begin
    data = reg_data;
    unique case (1'b1)
      mem_hit: data = mem_data;
      wb_sel:  data = wb_data;
      reg_sel: data = reg_data;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with WB capture bypass, EX operand forwarding
// and load-use stall detection feeding the ALU.
module ex_operand_stage
  import cpu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                reset,
  ex_operand_stage_if.slave   id,
  input  logic                flush,
  input  logic                mem_RegWrite,
  input  logic [REG_AW-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]   mem_result,
  input  logic                wb_RegWrite,
  input  logic [REG_AW-1:0]   wb_rd_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  output logic [5:0]          ALUFun,
  output logic                Sign,
  output logic                ex_valid,
  output logic [REG_AW-1:0]   ex_rd_addr,
  output logic                ex_RegWrite,
  output logic                ex_MemRead,
  output logic [DATA_W-1:0]   ex_store_data,
  output logic                stall
);

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [4:0]        shamt_q;
  logic [REG_AW-1:0] rs_addr_q;
  logic [REG_AW-1:0] rt_addr_q;
  logic              src1_q;
  logic              src2_q;

  logic [DATA_W-1:0] cap_rs_data;
  logic [DATA_W-1:0] cap_rt_data;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              wb_ok;
  logic              bubble;

  assign stall = id.id_valid & ex_valid & ex_MemRead
               & (ex_rd_addr != ZERO)
               & ((ex_rd_addr == id.id_rs_addr)
                | (ex_rd_addr == id.id_rt_addr));

  assign bubble = flush | stall;

  // WB writes the regfile this same cycle; ID read the old value
  assign wb_ok = wb_RegWrite & (wb_rd_addr != ZERO);
  assign cap_rs_data =
    (wb_ok && wb_rd_addr == id.id_rs_addr) ? wb_data
                                           : id.id_rs_data;
  assign cap_rt_data =
    (wb_ok && wb_rd_addr == id.id_rt_addr) ? wb_data
                                           : id.id_rt_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_rd_addr  <= '0;
      ALUFun      <= ALU_ADD;
      Sign        <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      src1_q      <= 1'b0;
      src2_q      <= 1'b0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_rd_addr  <= '0;
      ALUFun      <= ALU_ADD;
      Sign        <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      src1_q      <= 1'b0;
      src2_q      <= 1'b0;
    end else begin
      ex_valid    <= id.id_valid;
      ex_RegWrite <= id.id_valid & id.id_RegWrite;
      ex_MemRead  <= id.id_valid & id.id_MemRead;
      ex_rd_addr  <= id.id_rd_addr;
      ALUFun      <= id.id_ALUFun;
      Sign        <= id.id_Sign;
      rs_data_q   <= cap_rs_data;
      rt_data_q   <= cap_rt_data;
      imm_q       <= id.id_imm;
      shamt_q     <= id.id_shamt;
      rs_addr_q   <= id.id_rs_addr;
      rt_addr_q   <= id.id_rt_addr;
      src1_q      <= id.id_ALUSrc1;
      src2_q      <= id.id_ALUSrc2;
    end
  end

  operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src_addr (rs_addr_q),
    .reg_data (rs_data_q),
    .mem_we   (mem_RegWrite),
    .mem_rd   (mem_rd_addr),
    .mem_data (mem_result),
    .wb_we    (wb_RegWrite),
    .wb_rd    (wb_rd_addr),
    .wb_data  (wb_data),
    .data     (fwd_rs)
  );

  operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src_addr (rt_addr_q),
    .reg_data (rt_data_q),
    .mem_we   (mem_RegWrite),
    .mem_rd   (mem_rd_addr),
    .mem_data (mem_result),
    .wb_we    (wb_RegWrite),
    .wb_rd    (wb_rd_addr),
    .wb_data  (wb_data),
    .data     (fwd_rt)
  );

  assign A = (src1_q == SRC1_SHAMT)
           ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
  assign B = (src2_q == SRC2_IMM) ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage with
// hand-computed expectations.
module tb_ex_operand_stage;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        mem_RegWrite;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_result;
  logic        wb_RegWrite;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic [31:0] A, B, ex_store_data;
  logic [5:0]  ALUFun;
  logic        Sign, ex_valid, ex_RegWrite, ex_MemRead, stall;
  logic [4:0]  ex_rd_addr;

  int n_vec = 0;
  int n_bad = 0;

  ex_operand_stage_if #(.DATA_W(32), .REG_AW(5)) id_bus ();

  ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .id            (id_bus.slave),
    .flush         (flush),
    .mem_RegWrite  (mem_RegWrite),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_RegWrite   (wb_RegWrite),
    .wb_rd_addr    (wb_rd_addr),
    .wb_data       (wb_data),
    .A             (A),
    .B             (B),
    .ALUFun        (ALUFun),
    .Sign          (Sign),
    .ex_valid      (ex_valid),
    .ex_rd_addr    (ex_rd_addr),
    .ex_RegWrite   (ex_RegWrite),
    .ex_MemRead    (ex_MemRead),
    .ex_store_data (ex_store_data),
    .stall         (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic id_op(input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [5:0] fun, input logic rw,
                       input logic mr);
    id_bus.id_valid    = v;
    id_bus.id_rs_addr  = rs;
    id_bus.id_rt_addr  = rt;
    id_bus.id_rd_addr  = rd;
    id_bus.id_rs_data  = rsd;
    id_bus.id_rt_data  = rtd;
    id_bus.id_ALUFun   = fun;
    id_bus.id_RegWrite = rw;
    id_bus.id_MemRead  = mr;
    id_bus.id_imm      = 32'h0;
    id_bus.id_shamt    = 5'd0;
    id_bus.id_Sign     = 1'b0;
    id_bus.id_ALUSrc1  = 1'b0;
    id_bus.id_ALUSrc2  = 1'b0;
  endtask

  task automatic fwd_off();
    mem_RegWrite = 1'b0; mem_rd_addr = 5'd0; mem_result = 32'h0;
    wb_RegWrite  = 1'b0; wb_rd_addr  = 5'd0; wb_data    = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with random inputs
    reset = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      id_op(1'b1, 5'($urandom), 5'($urandom), 5'($urandom),
            $urandom, $urandom, 6'($urandom), 1'b1, 1'b1);
      id_bus.id_ALUSrc1 = 1'($urandom);
      id_bus.id_ALUSrc2 = 1'($urandom);
      id_bus.id_imm     = $urandom;
      id_bus.id_shamt   = 5'($urandom);
      mem_RegWrite = 1'b1; mem_rd_addr = 5'($urandom);
      mem_result = $urandom;
      wb_RegWrite = 1'b1; wb_rd_addr = 5'($urandom);
      wb_data = $urandom;
      tick();
    end
    check("rst_A", A, 32'h0);
    check("rst_B", B, 32'h0);
    check("rst_alufun", {26'h0, ALUFun}, 32'h0);
    check("rst_sign", {31'h0, Sign}, 32'h0);
    check("rst_valid", {31'h0, ex_valid}, 32'h0);
    check("rst_regwrite", {31'h0, ex_RegWrite}, 32'h0);
    check("rst_memread", {31'h0, ex_MemRead}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_store", ex_store_data, 32'h0);

    // sub r4,r3,r5 ; r3 comes from MEM
    @(negedge clk);
    reset = 1'b1;
    fwd_off();
    id_op(1'b1, 5'd3, 5'd5, 5'd4, 32'hDEAD_BEEF, 32'h5,
          ALU_SUB, 1'b1, 1'b0);
    tick();
    id_op(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b0);
    mem_RegWrite = 1'b1; mem_rd_addr = 5'd3; mem_result = 32'h10;
    #1;
    check("memfwd_A", A, 32'h10);
    check("memfwd_B", B, 32'h5);
    check("memfwd_alufun", {26'h0, ALUFun}, 32'h1);
    check("memfwd_valid", {31'h0, ex_valid}, 32'h1);
    check("memfwd_rd", {27'h0, ex_rd_addr}, 32'd4);
    check("memfwd_rw", {31'h0, ex_RegWrite}, 32'h1);

    // MEM and WB both target r3
    mem_result = 32'hAAAA_0000;
    wb_RegWrite = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'h1234;
    #1;
    check("dbl_A", A, 32'hAAAA_0000);
    mem_RegWrite = 1'b0;
    #1;
    check("wbfwd_A", A, 32'h1234);

    // rs = r0: never forwarded
    fwd_off();
    id_op(1'b1, 5'd0, 5'd5, 5'd4, 32'h7, 32'h5, ALU_ADD, 1'b1, 1'b0);
    tick();
    id_op(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b0);
    mem_RegWrite = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'hAAAA_0000;
    wb_RegWrite = 1'b1; wb_rd_addr = 5'd0; wb_data = 32'h1234;
    #1;
    check("r0_A", A, 32'h7);

    // load-use: lw r2 then or r6,r2,r1
    fwd_off();
    id_op(1'b1, 5'd1, 5'd0, 5'd2, 32'h0, 32'h0, ALU_ADD, 1'b1, 1'b1);
    tick();
    id_op(1'b1, 5'd2, 5'd1, 5'd6, 32'h0, 32'h11, ALU_OR, 1'b1, 1'b0);
    #1;
    check("lu_memread", {31'h0, ex_MemRead}, 32'h1);
    check("lu_stall", {31'h0, stall}, 32'h1);
    tick();
    check("lu_bubble_valid", {31'h0, ex_valid}, 32'h0);
    check("lu_bubble_A", A, 32'h0);
    check("lu_bubble_alufun", {26'h0, ALUFun}, 32'h0);
    check("lu_stall_drop", {31'h0, stall}, 32'h0);
    mem_RegWrite = 1'b1; mem_rd_addr = 5'd2; mem_result = 32'h55;
    tick();
    check("lu_fwd_A", A, 32'h55);
    check("lu_B", B, 32'h11);
    check("lu_alufun", {26'h0, ALUFun}, {26'h0, ALU_OR});
    check("lu_valid", {31'h0, ex_valid}, 32'h1);

    // flush together with stall
    fwd_off();
    id_op(1'b1, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, ALU_ADD, 1'b1, 1'b1);
    tick();
    id_op(1'b1, 5'd7, 5'd1, 5'd8, 32'h3, 32'h4, ALU_SUB, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_stall", {31'h0, stall}, 32'h1);
    tick();
    flush = 1'b0;
    check("fl_valid", {31'h0, ex_valid}, 32'h0);
    check("fl_regwrite", {31'h0, ex_RegWrite}, 32'h0);

    // shift/immediate with rt forwarded to store data
    id_op(1'b1, 5'd9, 5'd8, 5'd10, 32'h0, 32'h0, ALU_SLL, 1'b1, 1'b0);
    id_bus.id_ALUSrc1 = 1'b1;
    id_bus.id_shamt   = 5'd5;
    id_bus.id_ALUSrc2 = 1'b1;
    id_bus.id_imm     = 32'hFFFF_FF00;
    tick();
    id_op(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b0);
    mem_RegWrite = 1'b1; mem_rd_addr = 5'd8; mem_result = 32'h99;
    #1;
    check("sh_A", A, 32'h5);
    check("sh_B", B, 32'hFFFF_FF00);
    check("sh_store", ex_store_data, 32'h99);

    // WB write racing the ID read is captured
    fwd_off();
    id_op(1'b1, 5'd10, 5'd11, 5'd12, 32'h1, 32'h2, ALU_ADD, 1'b1, 1'b0);
    wb_RegWrite = 1'b1; wb_rd_addr = 5'd10; wb_data = 32'h77;
    tick();
    fwd_off();
    #1;
    check("cap_A", A, 32'h77);
    check("cap_B", B, 32'h2);

    // invalid ID gates RegWrite/MemRead
    id_op(1'b0, 5'd1, 5'd1, 5'd3, 32'h0, 32'h0, ALU_ADD, 1'b1, 1'b1);
    tick();
    check("inv_valid", {31'h0, ex_valid}, 32'h0);
    check("inv_rw", {31'h0, ex_RegWrite}, 32'h0);
    check("inv_mr", {31'h0, ex_MemRead}, 32'h0);

    // async reset mid-hazard
    id_op(1'b1, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0, ALU_ADD, 1'b1, 1'b1);
    tick();
    id_op(1'b1, 5'd2, 5'd0, 5'd6, 32'h0, 32'h0, ALU_OR, 1'b1, 1'b0);
    #1;
    check("mid_stall_pre", {31'h0, stall}, 32'h1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_stall", {31'h0, stall}, 32'h0);
    check("mid_valid", {31'h0, ex_valid}, 32'h0);
    check("mid_memread", {31'h0, ex_MemRead}, 32'h0);
    check("mid_rd", {27'h0, ex_rd_addr}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection. It sits directly upstream of the ALU and drives its A, B, ALUFun and Sign inputs. It captures decoded operands and control from ID, bypasses in-flight results from MEM and WB, and inserts bubbles on load-use hazards or branch flush.

Parameters:
DATA_W, 32, datapath width (A/B/result width)
REG_AW, 5, register address width (register 0 hardwired zero, never forwarded)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_data  in  DATA_W  register-file rs read value
id_rt_data  in  DATA_W  register-file rt read value
id_imm  in  DATA_W  extended immediate
id_shamt  in  5  shift amount field
id_rs_addr  in  REG_AW  rs index
id_rt_addr  in  REG_AW  rt index
id_rd_addr  in  REG_AW  destination index
id_ALUFun  in  6  ALU function code
id_Sign  in  1  signed compare/overflow select
id_ALUSrc1  in  1  0: A=rs, 1: A={27'b0,shamt}
id_ALUSrc2  in  1  0: B=rt, 1: B=imm
id_RegWrite  in  1  instruction writes rd
id_MemRead  in  1  instruction is a load
flush  in  1  branch/jump resolved taken; kill ID instruction
mem_RegWrite  in  1  MEM-stage instruction writes register
mem_rd_addr  in  REG_AW  MEM-stage destination
mem_result  in  DATA_W  MEM-stage ALU result
wb_RegWrite  in  1  WB-stage write enable
wb_rd_addr  in  REG_AW  WB destination
wb_data  in  DATA_W  WB write data
A  out  DATA_W  ALU operand A (combinational from registers + forwarding)
B  out  DATA_W  ALU operand B
ALUFun  out  6  registered ALU function
Sign  out  1  registered sign select
ex_valid  out  1  EX holds a real instruction
ex_rd_addr  out  REG_AW  registered destination
ex_RegWrite  out  1  registered, gated by ex_valid
ex_MemRead  out  1  registered, gated by ex_valid
ex_store_data  out  DATA_W  forwarded rt value (store data)
stall  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset (reset=0, async): all registers 0. ALUFun=000000 (add), Sign=0, ex_valid/ex_RegWrite/ex_MemRead=0, A=B=0, stall=0.
- Latency: ID inputs appear on EX outputs one clock after capture.
- stall = id_valid & ex_valid & ex_MemRead & ex_rd_addr!=0 & (ex_rd_addr==id_rs_addr | ex_rd_addr==id_rt_addr). Conservative: asserted even when the ID instruction uses an immediate.
- Per clock edge, priority: flush > stall > capture.
  - flush=1 or stall=1: load bubble (ex_valid=0, RegWrite=0, MemRead=0, all data/addr fields 0).
  - Otherwise: capture all id_* fields; ex_valid=id_valid; RegWrite/MemRead gated by id_valid.
- Capture bypass: if wb_RegWrite & wb_rd_addr!=0 & wb_rd_addr==id_rs_addr, capture wb_data instead of id_rs_data. Same rule for rt. Covers the WB write racing the ID read.
- EX forwarding, per operand, on registered rs/rt:
  - src = MEM if mem_RegWrite & mem_rd_addr!=0 & match.
  - Else WB if wb_RegWrite & wb_rd_addr!=0 & match.
  - Else registered value.
  - MEM beats WB when both match.
- A = ALUSrc1 ? {27'b0,shamt} : fwd_rs. B = ALUSrc2 ? imm : fwd_rt. ex_store_data = fwd_rt always.
- Bubble in EX yields A=B=0, ALUFun=add. The ALU result is ignored because RegWrite=0.
- flush and stall in the same cycle: bubble inserted; stall output still asserted as computed.
- Reset mid-operation: immediate clear; stall drops to 0 because ex_valid=0.

Decomposition:
- Shared package cpu_defs:
  - ALUFun codes (ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111).
  - ALUSrc encodings, REG_ZERO constant.
- One sub-module: operand_fwd (address compare + 3-way priority mux), instantiated for rs and rt.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0, stall=0. Release -> first clock captures ID.
- MEM forward: add r3 in MEM (mem_result=0x0000_0010). EX holds `sub r4,r3,r5` with rt reg=0x5 -> A=0x10, B=0x5, ALUFun=000001.
- Double hazard: mem_rd=wb_rd=r3, mem_result=0xAAAA_0000, wb_data=0x1234 -> A=0xAAAA_0000. Repeat with rd=r0, reg=0x7 -> A=0x7.
- Load-use: lw r2 in EX (ex_MemRead=1), ID `or r6,r2,r1` -> stall=1, next cycle ex_valid=0. Following cycle r2 forwarded from MEM.
- Flush with stall: flush=1 and stall=1 same cycle -> next ex_valid=0, ex_RegWrite=0.
- Shift/immediate: ALUSrc1=1, shamt=5, ALUSrc2=1, imm=0xFFFF_FF00, rt forward active (0x99) -> A=5, B=0xFFFF_FF00, ex_store_data=0x99.
